axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ID_IF, default 4'd0, ARID/RID value tagging instruction-fetch transactions.
REQ-002 Parameter ID_MEM, default 4'd1, ARID/RID value tagging data-load transactions.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 if_req  in  1  fetch request; held with if_addr stable until if_gnt.
REQ-006 if_addr  in  64  fetch address; size fixed 4 bytes.
REQ-007 if_gnt  out  1  one-cycle pulse: fetch address accepted on AR.
REQ-008 if_rvalid / if_rerr  out  1 / 1  one-cycle fetch response pulse / RRESP!=OKAY flag, valid with if_rvalid.
REQ-009 if_rdata  out  64  fetch response data, valid with if_rvalid.
REQ-010 mem_req / mem_addr / mem_size  in  1 / 64 / 3  load request, address, AxSIZE code; held stable until mem_gnt.
REQ-011 mem_gnt, mem_rvalid, mem_rerr, mem_rdata  out  1,1,1,64  same meaning as fetch counterparts.
REQ-012 ARID 4, ARADDR 64, ARLEN 8, ARSIZE 3, ARBURST 2, ARPROT 3, ARVALID 1  out  AXI read-address channel.
REQ-013 ARREADY  in  1  AXI read-address ready.
REQ-014 RID 4, RDATA 64, RRESP 2, RLAST 1, RVALID 1  in  AXI read-data channel.
REQ-015 RREADY  out  1  AXI read-data ready.
REQ-016 stray_err  out  1  sticky: an R beat arrived that matched no outstanding transaction.

Function
REQ-017 FSM states IDLE, ADDR, RESP; exactly one AXI read outstanding at any time.
REQ-018 IDLE: any req high -> register winner's payload, ARVALID<=1, go ADDR; no req -> stay IDLE, ARVALID=0.
REQ-019 Arbitration: single req wins; both high -> grant port not granted last (round-robin); last-grant pointer updates only on AR handshake.
REQ-020 Payload: ARLEN=0, ARBURST=INCR (2'b01); fetch ARSIZE=3'b010, ARPROT=3'b100, ARID=ID_IF; load ARSIZE=mem_size, ARPROT=3'b000, ARID=ID_MEM.
REQ-021 ADDR: ARVALID and all AR payload held constant until ARREADY; requester req/addr changes ignored.
REQ-022 ADDR with ARREADY=1: owner's gnt pulses combinationally that cycle, ARVALID<=0, go RESP.
REQ-023 RESP: RREADY=1; RREADY=0 in IDLE and ADDR.
REQ-024 RESP completion: RVALID & RLAST & RID==owner ID -> owner's rvalid pulses same cycle, rdata=RDATA, rerr=(RRESP!=2'b00).
REQ-025 Completion with any req high -> arbitrate per REQ-019, load AR payload, ARVALID=1 next cycle, go ADDR (no idle bubble); else go IDLE.
REQ-026 req still high at completion is a new request from that port.
REQ-027 RVALID in RESP with RID!=owner ID, or RLAST=0: beat consumed, no rvalid pulse, stray_err<=1, state unchanged.
REQ-028 RVALID while not in RESP: ignored (RREADY=0), no outputs change.
REQ-029 Non-owner port never sees gnt or rvalid; if_* and mem_* pulses never coincide.
REQ-030 Minimum latency: req at cycle N in IDLE -> ARVALID N+1; ARREADY at N+1 -> gnt at N+1; RVALID at N+2 -> rvalid at N+2.

Reset
REQ-031 rstn=0 at a rising edge: state IDLE, ARVALID=0, RREADY=0, AR payload=0, stray_err=0, last-grant=fetch (load wins first tie).
REQ-032 Reset mid-transaction abandons it: no gnt or rvalid emitted for it; any later R beat is handled per REQ-028/REQ-027.
REQ-033 gnt and rvalid outputs are 0 in every cycle rstn=0.

Verification
REQ-034 Fetch only, addr 0x80000000, ARREADY=1, RDATA=0x13 RID=0 RLAST=1 next cycle -> ARID=0, ARSIZE=2, ARPROT=4, if_gnt 1 cycle, if_rvalid with if_rdata=0x13, if_rerr=0.
REQ-035 if_req and mem_req both high from reset, held -> grants alternate mem, if, mem, if; ARVALID returns 1 cycle after each completion.
REQ-036 ARREADY low 5 cycles -> ARVALID and ARADDR stable 5 cycles; one gnt on cycle 6; mem_addr change during wait not reflected.
REQ-037 Load outstanding, beat RID=0 arrives -> stray_err=1, no rvalid; following RID=1 beat -> mem_rvalid pulse.
REQ-038 Load response RRESP=2'b10 -> mem_rvalid with mem_rerr=1; rstn=0 in RESP -> no rvalid, ARVALID=0, stray_err=0 next cycle.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// axi_rd_arbiter: round-robin fetch/load arbiter onto one AXI read channel,
// single transaction outstanding.                       Revision: 1.0
// ============================================================================
module axi_rd_arbiter #(
  parameter logic [3:0] ID_IF  = 4'd0,
  parameter logic [3:0] ID_MEM = 4'd1
) (
  input  logic        clk,
  input  logic        rstn,
  // instruction fetch port
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic        if_rerr_o,
  output logic [63:0] if_rdata_o,
  // data load port
  input  logic        mem_req_i,
  input  logic [63:0] mem_addr_i,
  input  logic [2:0]  mem_size_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic        mem_rerr_o,
  output logic [63:0] mem_rdata_o,
  // AXI read address channel
  output logic [3:0]  arid_o,
  output logic [63:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic [2:0]  arprot_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  // AXI read data channel
  input  logic [3:0]  rid_i,
  input  logic [63:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic        stray_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;        // 1: load port owns the transaction
  logic        last_mem_q, last_mem_d;  // 1: load port won the last AR handshake
  logic [3:0]  arid_q, arid_d;
  logic [63:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [1:0]  arburst_q, arburst_d;
  logic [2:0]  arprot_q, arprot_d;
  logic        stray_q, stray_d;

  logic any_req;
  logic pick_mem;
  logic load;
  logic gnt_pulse;
  logic done_pulse;

  assign any_req  = if_req_i | mem_req_i;
  assign pick_mem = mem_req_i & (~if_req_i | ~last_mem_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_mem_d = last_mem_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    arprot_d   = arprot_q;
    stray_d    = stray_q;
    load       = 1'b0;
    gnt_pulse  = 1'b0;
    done_pulse = 1'b0;
    rready_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) load = 1'b1;
      end
      S_ADDR: begin
        if (arready_i) begin
          gnt_pulse  = 1'b1;
          last_mem_d = owner_q;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          // arid_q still carries the owner's ID, so it doubles as the match key
          if (rlast_i && (rid_i == arid_q)) begin
            done_pulse = 1'b1;
            if (any_req) load = 1'b1;
            else         state_d = S_IDLE;
          end else begin
            stray_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d   = S_ADDR;
      owner_d   = pick_mem;
      arburst_d = 2'b01;
      if (pick_mem) begin
        arid_d   = ID_MEM;
        araddr_d = mem_addr_i;
        arsize_d = mem_size_i;
        arprot_d = 3'b000;
      end else begin
        arid_d   = ID_IF;
        araddr_d = if_addr_i;
        arsize_d = 3'b010;
        arprot_d = 3'b100;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_mem_q <= 1'b0;
      arid_q     <= 4'd0;
      araddr_q   <= 64'd0;
      arsize_q   <= 3'd0;
      arburst_q  <= 2'd0;
      arprot_q   <= 3'd0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_mem_q <= last_mem_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      arprot_q   <= arprot_d;
      stray_q    <= stray_d;
    end
  end

  assign arid_o      = arid_q;
  assign araddr_o    = araddr_q;
  assign arlen_o     = 8'd0;
  assign arsize_o    = arsize_q;
  assign arburst_o   = arburst_q;
  assign arprot_o    = arprot_q;
  assign arvalid_o   = (state_q == S_ADDR);
  assign stray_err_o = stray_q;

  // Pulses are masked during reset so an abandoned transaction never completes
  assign if_gnt_o     = rstn & gnt_pulse & ~owner_q;
  assign mem_gnt_o    = rstn & gnt_pulse & owner_q;
  assign if_rvalid_o  = rstn & done_pulse & ~owner_q;
  assign mem_rvalid_o = rstn & done_pulse & owner_q;
  assign if_rerr_o    = if_rvalid_o & (rresp_i != 2'b00);
  assign mem_rerr_o   = mem_rvalid_o & (rresp_i != 2'b00);
  assign if_rdata_o   = rdata_i;
  assign mem_rdata_o  = rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// Randomized requesters and AXI slave for axi_rd_arbiter, scoreboarded
// against a transaction-level model of arbitration and response routing.
module tb_axi_rd_arbiter;
  localparam logic [3:0] ID_IF  = 4'd0;
  localparam logic [3:0] ID_MEM = 4'd1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, mem_req;
  logic [63:0] if_addr, mem_addr;
  logic [2:0]  mem_size;
  logic        if_gnt_o, if_rvalid_o, if_rerr_o, mem_gnt_o, mem_rvalid_o, mem_rerr_o;
  logic [63:0] if_rdata_o, mem_rdata_o;
  logic [3:0]  arid_o;
  logic [63:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o, arprot_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o, arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready_o, stray_err_o;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID_IF(ID_IF), .ID_MEM(ID_MEM)) dut (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rerr_o(if_rerr_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req), .mem_addr_i(mem_addr), .mem_size_i(mem_size),
    .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o), .mem_rerr_o(mem_rerr_o),
    .mem_rdata_o(mem_rdata_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
    .rready_o(rready_o), .stray_err_o(stray_err_o)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  prot;
  } ar_t;

  typedef struct packed {
    logic        is_mem;
    logic [63:0] data;
    logic        err;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  errors = 0;
  int  checks = 0;
  int  n_done = 0;

  // Transaction model: a read is either waiting for its address handshake,
  // waiting for its final beat, or there is none.
  bit started = 0, st_ar = 0, st_resp = 0, own_mem = 0, last_mem = 0, stray_exp = 0;
  bit if_gntd = 0, mem_gntd = 0;

  int p_if = 0, p_mem = 0, p_ardy = 100, p_resp = 100, p_stray = 0;
  int p_junk = 0, p_glitch = 0, p_rst = 0;
  bit fix = 0, force_rst = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [3:0] own_id();
    return own_mem ? ID_MEM : ID_IF;
  endfunction

  task automatic model_edge();
    ar_t a;
    if_gntd  = 0;
    mem_gntd = 0;
    if (!rstn) begin
      st_ar = 0; st_resp = 0; last_mem = 0; stray_exp = 0; started = 1;
      ar_q.delete();
      r_q.delete();
    end else begin
      if (st_resp && rvalid) begin
        if (rlast && rid == own_id()) begin
          st_resp = 0;
          n_done++;
        end else begin
          stray_exp = 1;
        end
      end else if (st_ar && arready) begin
        st_ar   = 0;
        st_resp = 1;
        if (own_mem) mem_gntd = 1;
        else         if_gntd  = 1;
      end
      if (!st_ar && !st_resp && (if_req || mem_req)) begin
        own_mem  = mem_req && (!if_req || !last_mem);
        last_mem = own_mem;
        a.len    = 8'd0;
        a.burst  = 2'b01;
        if (own_mem) begin
          a.id = ID_MEM; a.addr = mem_addr; a.size = mem_size; a.prot = 3'b000;
        end else begin
          a.id = ID_IF;  a.addr = if_addr;  a.size = 3'b010;   a.prot = 3'b100;
        end
        ar_q.push_back(a);
        st_ar = 1;
      end
    end
  endtask

  task automatic drive();
    r_t e;
    rstn = !(force_rst || roll(p_rst));
    if (!(if_req && !if_gntd)) begin
      if_req  = roll(p_if);
      if_addr = fix ? 64'h8000_0000 : rnd64();
    end else if (st_ar && !own_mem && roll(p_glitch)) begin
      if_addr = rnd64();
    end
    if (!(mem_req && !mem_gntd)) begin
      mem_req  = roll(p_mem);
      mem_addr = rnd64();
      mem_size = 3'($urandom_range(0, 3));
    end else if (st_ar && own_mem && roll(p_glitch)) begin
      mem_addr = rnd64();
      mem_size = 3'($urandom_range(0, 3));
    end
    arready = roll(p_ardy);
    rvalid  = 1'b0;
    rid     = 4'($urandom);
    rlast   = 1'($urandom);
    rresp   = 2'($urandom);
    rdata   = rnd64();
    if (!rstn) begin
      if (st_resp) begin
        rvalid = 1'b1; rid = own_id(); rlast = 1'b1;
      end
    end else if (st_resp) begin
      if (roll(p_stray)) begin
        rvalid = 1'b1;
        if ($urandom_range(0, 1) == 0) rid = own_id() ^ 4'($urandom_range(1, 15));
        else begin
          rid = own_id(); rlast = 1'b0;
        end
      end else if (roll(p_resp)) begin
        rvalid = 1'b1; rid = own_id(); rlast = 1'b1;
        if (fix) begin
          rdata = 64'h13; rresp = 2'b00;
        end else begin
          rresp = roll(30) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        e.is_mem = own_mem;
        e.data   = rdata;
        e.err    = (rresp != 2'b00);
        r_q.push_back(e);
      end
    end else begin
      rvalid = roll(p_junk);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive();
  endtask

  always @(negedge clk) begin
    r_t e;
    if (started) begin
      chk("arvalid", 128'(arvalid_o), 128'(st_ar));
      chk("rready", 128'(rready_o), 128'(st_resp));
      chk("stray_err", 128'(stray_err_o), 128'(stray_exp));
      if (!rstn) begin
        chk("pulses_in_reset", 128'({if_gnt_o, mem_gnt_o, if_rvalid_o, mem_rvalid_o}), 128'(0));
      end else begin
        chk("gnt", 128'({if_gnt_o, mem_gnt_o}),
            128'((st_ar && arready) ? (own_mem ? 2'b01 : 2'b10) : 2'b00));
        if (st_ar && ar_q.size() > 0) begin
          chk("ar_payload", 128'({arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arprot_o}),
              128'(ar_q[0]));
          if (arready) void'(ar_q.pop_front());
        end
        if (r_q.size() > 0) begin
          e = r_q.pop_front();
          chk("rvalid", 128'({if_rvalid_o, mem_rvalid_o}), 128'(e.is_mem ? 2'b01 : 2'b10));
          chk("rdata", 128'(e.is_mem ? mem_rdata_o : if_rdata_o), 128'(e.data));
          chk("rerr", 128'(e.is_mem ? mem_rerr_o : if_rerr_o), 128'(e.err));
        end else begin
          chk("rvalid_idle", 128'({if_rvalid_o, mem_rvalid_o}), 128'(0));
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; if_req = 1'b0; mem_req = 1'b0; if_addr = '0; mem_addr = '0; mem_size = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    force_rst = 1; repeat (3) step(); force_rst = 0;

    // fetch only, fixed address and data, zero-wait slave
    fix = 1; p_if = 100; p_mem = 0; p_ardy = 100; p_resp = 100;
    repeat (8) step();

    // both requesters held high from reset: grants must alternate
    fix = 0; force_rst = 1; step(); force_rst = 0;
    p_if = 100; p_mem = 100;
    repeat (24) step();

    // slow slave, stray beats, address changes while waiting for ARREADY
    p_if = 40; p_mem = 40; p_ardy = 20; p_resp = 35; p_stray = 15; p_junk = 30; p_glitch = 30;
    repeat (1500) step();

    // random resets on top of random traffic
    p_rst = 2; p_ardy = 60; p_resp = 60;
    repeat (2000) step();

    p_rst = 0; p_if = 0; p_mem = 0; p_stray = 0; p_ardy = 100; p_resp = 100;
    repeat (20) step();
    chk("progress", 128'(n_done > 100), 128'(1));
    chk("queues_drained", 128'(ar_q.size() + r_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
